// File: rtl/button_debounce_array.sv
// Multi-channel push-button conditioner: synchronise, debounce, and report
// press, release and long-press events per channel.
module button_debounce_array #(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = 500000,
    parameter int CNT_W      = 20,
    parameter int LONG_CNT   = 50000000,
    parameter int LONG_W     = 26,
    parameter int IDLE_LEVEL = 1
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [N_CH-1:0] Button_In,
    output logic [N_CH-1:0] Button_Level,
    output logic [N_CH-1:0] Press_Pulse,
    output logic [N_CH-1:0] Release_Pulse,
    output logic [N_CH-1:0] Long_Pulse
);

    localparam logic              IDLE_BIT  = (IDLE_LEVEL != 0);
    localparam logic [N_CH-1:0]   IDLE_VEC  = {N_CH{IDLE_BIT}};
    localparam logic [CNT_W-1:0]  DCNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [LONG_W-1:0] HCNT_LAST = LONG_W'(LONG_CNT - 1);

    logic [N_CH-1:0]   s1;
    logic [N_CH-1:0]   s2;
    logic [N_CH-1:0]   stable;
    logic [N_CH-1:0]   pressed;
    logic [N_CH-1:0]   long_done;
    logic [CNT_W-1:0]  dcnt [N_CH];
    logic [LONG_W-1:0] hcnt [N_CH];

    // Normalised pressed state of the accepted level, before output registering.
    assign pressed = stable ^ IDLE_VEC;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1            <= IDLE_VEC;
            s2            <= IDLE_VEC;
            stable        <= IDLE_VEC;
            long_done     <= '0;
            Button_Level  <= '0;
            Press_Pulse   <= '0;
            Release_Pulse <= '0;
            Long_Pulse    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dcnt[i] <= '0;
                hcnt[i] <= '0;
            end
        end else begin
            s1 <= Button_In;
            s2 <= s1;
            for (int i = 0; i < N_CH; i++) begin
                if (s2[i] == stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DCNT_LAST) begin
                    stable[i] <= s2[i];
                    dcnt[i]   <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end

                Button_Level[i]  <= pressed[i];
                Press_Pulse[i]   <= pressed[i] & ~Button_Level[i];
                Release_Pulse[i] <= ~pressed[i] & Button_Level[i];
                Long_Pulse[i]    <= 1'b0;

                // A release accepted on the same edge the hold count completes
                // drops pressed first, so the long pulse is withheld.
                if (!Button_Level[i]) begin
                    hcnt[i]      <= '0;
                    long_done[i] <= 1'b0;
                end else if (!long_done[i]) begin
                    if (hcnt[i] == HCNT_LAST) begin
                        long_done[i]  <= 1'b1;
                        Long_Pulse[i] <= pressed[i];
                    end else begin
                        hcnt[i] <= hcnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_button_debounce_array.sv
// Scoreboard bench for button_debounce_array with N_CH=2, STABLE_CNT=4,
// LONG_CNT=10, active-low buttons.
module tb_button_debounce_array;

    localparam int N_CH         = 2;
    localparam int KIND_PRESS   = 0;
    localparam int KIND_RELEASE = 1;
    localparam int KIND_LONG    = 2;

    typedef struct {
        int at;
        int ch;
        int kind;
    } ev_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] btn   = '1;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] release_p;
    logic [N_CH-1:0] long_p;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];
    int   n;
    int   m;

    button_debounce_array #(
        .N_CH(N_CH), .STABLE_CNT(4), .CNT_W(4),
        .LONG_CNT(10), .LONG_W(5), .IDLE_LEVEL(1)
    ) dut (
        .CLK(clk),
        .RSTn(rst_n),
        .Button_In(btn),
        .Button_Level(level),
        .Press_Pulse(press),
        .Release_Pulse(release_p),
        .Long_Pulse(long_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic pulse_of(int ch, int kind);
        case (kind)
            KIND_PRESS:   return press[ch];
            KIND_RELEASE: return release_p[ch];
            default:      return long_p[ch];
        endcase
    endfunction

    function automatic string kname(int kind);
        case (kind)
            KIND_PRESS:   return "press";
            KIND_RELEASE: return "release";
            default:      return "long";
        endcase
    endfunction

    task automatic expect_ev(int ch, int kind, int at);
        ev_t e;
        e.at   = at;
        e.ch   = ch;
        e.kind = kind;
        sb.push_back(e);
    endtask

    task automatic step(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse seen must match a queued event at exactly this cycle.
    initial begin : monitor
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_%s ch%0d: no pulse, required at cycle %0d",
                             kname(sb[i].kind), sb[i].ch, sb[i].at);
                    sb.delete(i);
                end
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    if (pulse_of(ch, k) !== 1'b0) begin
                        int idx;
                        idx = -1;
                        for (int i = 0; i < sb.size(); i++)
                            if (idx < 0 && sb[i].ch == ch && sb[i].kind == k) idx = i;
                        checks++;
                        if (idx < 0) begin
                            errors++;
                            $display("FAIL unexpected_%s ch%0d: pulse %b at cycle %0d, none required",
                                     kname(k), ch, pulse_of(ch, k), cyc);
                        end else begin
                            if (sb[idx].at != cyc) begin
                                errors++;
                                $display("FAIL early_%s ch%0d: pulse at cycle %0d, required at %0d",
                                         kname(k), ch, cyc, sb[idx].at);
                            end
                            sb.delete(idx);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        step(3);
        check("reset_outputs", {24'd0, level, press, release_p, long_p}, 32'd0);
        rst_n = 1'b1;
        step(3);

        // Clean press on ch0, held 30 cycles past acceptance, then released.
        n = cyc;
        btn[0] = 1'b0;
        expect_ev(0, KIND_PRESS, n + 7);
        expect_ev(0, KIND_LONG, n + 17);
        step(6);
        check("level_before_accept", level, 2'b00);
        step(1);
        check("level_after_accept", level, 2'b01);
        step(30);
        m = cyc;
        btn[0] = 1'b1;
        expect_ev(0, KIND_RELEASE, m + 7);
        step(6);
        check("level_before_release", level, 2'b01);
        step(1);
        check("level_after_release", level, 2'b00);
        step(5);

        // Three-cycle glitch is rejected.
        btn[0] = 1'b0;
        step(3);
        btn[0] = 1'b1;
        step(12);
        check("short_glitch_level", level, 2'b00);

        // Four-cycle excursion is just long enough to be accepted both ways.
        n = cyc;
        btn[0] = 1'b0;
        expect_ev(0, KIND_PRESS, n + 7);
        step(4);
        btn[0] = 1'b1;
        expect_ev(0, KIND_RELEASE, n + 11);
        step(14);

        // Bounce 0/1/0/1 at 3-cycle intervals, then settle low.
        btn[0] = 1'b0; step(3);
        btn[0] = 1'b1; step(3);
        btn[0] = 1'b0; step(3);
        btn[0] = 1'b1; step(3);
        n = cyc;
        btn[0] = 1'b0;
        expect_ev(0, KIND_PRESS, n + 7);
        step(8);
        btn[0] = 1'b1;
        expect_ev(0, KIND_RELEASE, n + 15);
        step(12);

        // Release accepted on the edge the hold count completes: no long pulse.
        n = cyc;
        btn[0] = 1'b0;
        expect_ev(0, KIND_PRESS, n + 7);
        step(10);
        btn[0] = 1'b1;
        expect_ev(0, KIND_RELEASE, n + 17);
        step(12);

        // Release one cycle later: long pulse fires, release follows.
        n = cyc;
        btn[0] = 1'b0;
        expect_ev(0, KIND_PRESS, n + 7);
        expect_ev(0, KIND_LONG, n + 17);
        expect_ev(0, KIND_RELEASE, n + 18);
        step(11);
        btn[0] = 1'b1;
        step(12);

        // Reset two cycles after acceptance while held, then re-acceptance.
        n = cyc;
        btn[0] = 1'b0;
        expect_ev(0, KIND_PRESS, n + 7);
        step(8);
        check("level_held_before_reset", level, 2'b01);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {24'd0, level, press, release_p, long_p}, 32'd0);
        step(2);
        check("reset_held_outputs", {24'd0, level, press, release_p, long_p}, 32'd0);
        rst_n = 1'b1;
        m = cyc;
        expect_ev(0, KIND_PRESS, m + 7);
        step(8);
        check("level_after_reset_press", level, 2'b01);
        btn[0] = 1'b1;
        expect_ev(0, KIND_RELEASE, m + 15);
        step(12);

        // Both channels pressed together.
        n = cyc;
        btn = 2'b00;
        expect_ev(0, KIND_PRESS, n + 7);
        expect_ev(1, KIND_PRESS, n + 7);
        step(7);
        check("level_both", level, 2'b11);
        step(2);
        btn = 2'b11;
        expect_ev(0, KIND_RELEASE, n + 16);
        expect_ev(1, KIND_RELEASE, n + 16);
        step(12);

        // Ch1 alone leaves ch0 untouched.
        n = cyc;
        btn[1] = 1'b0;
        expect_ev(1, KIND_PRESS, n + 7);
        step(7);
        check("level_ch1_only", level, 2'b10);
        btn[1] = 1'b1;
        expect_ev(1, KIND_RELEASE, n + 14);
        step(12);
        check("level_final", level, 2'b00);

        step(4);
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL pending_%s ch%0d: no pulse, required at cycle %0d",
                     kname(sb[0].kind), sb[0].ch, sb[0].at);
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
